// File: rtl/lif_neuron_mc.sv
// lif_neuron_mc: multi-input leaky integrate-and-fire neuron with saturating
// accumulation, zero/subtract reset on fire and a latched refractory period.
module lif_neuron_mc #(
    parameter int NUM_INPUTS   = 8,
    parameter int WEIGHT_W     = 8,
    parameter int POT_W        = 16,
    parameter int LEAK_SHIFT_W = 4,
    parameter int REFRAC_W     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [NUM_INPUTS-1:0]          input_spike,
    input  logic [NUM_INPUTS*WEIGHT_W-1:0] weights,
    input  logic signed [POT_W-1:0]        threshold,
    input  logic [LEAK_SHIFT_W-1:0]        leak_shift,
    input  logic [REFRAC_W-1:0]            refrac_period,
    input  logic                           reset_mode,
    output logic                           output_spike,
    output logic signed [POT_W-1:0]        membrane_potential,
    output logic                           refractory
);
    localparam int SUM_W = WEIGHT_W + $clog2(NUM_INPUTS) + 1;
    localparam int EXT_W = POT_W + SUM_W + 1;
    localparam logic signed [EXT_W-1:0] V_MAX = {{(EXT_W-POT_W+1){1'b0}}, {(POT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] V_MIN = {{(EXT_W-POT_W+1){1'b1}}, {(POT_W-1){1'b0}}};

    typedef enum logic {ACTIVE, REFRACTORY} state_t;

    state_t                  state_q;
    logic signed [POT_W-1:0] v_q, v_d, v_sum, v_sub, leak_amt;
    logic [REFRAC_W-1:0]     cnt_q;
    logic                    spike_q, fire;
    logic signed [SUM_W-1:0] sum;
    logic signed [EXT_W-1:0] leaked;

    function automatic logic signed [POT_W-1:0] sat(input logic signed [EXT_W-1:0] x);
        return (x > V_MAX) ? V_MAX[POT_W-1:0] : (x < V_MIN) ? V_MIN[POT_W-1:0] : x[POT_W-1:0];
    endfunction

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_INPUTS; i++)
            if (input_spike[i]) sum = sum + SUM_W'($signed(weights[i*WEIGHT_W +: WEIGHT_W]));
        leak_amt = v_q >>> leak_shift;
        leaked   = EXT_W'(v_q) - ((leak_shift != '0) ? EXT_W'(leak_amt) : EXT_W'(0));
        v_sum    = sat(leaked + EXT_W'(sum));
        fire     = v_sum >= threshold;
        v_sub    = sat(EXT_W'(v_sum) - EXT_W'(threshold));
        v_d      = fire ? (reset_mode ? v_sub : '0) : v_sum;
    end

    // The refractory length is captured into cnt_q at fire time, so later
    // changes to refrac_period only affect the next period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACTIVE;
            v_q     <= '0;
            cnt_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            spike_q <= enable && state_q == ACTIVE && fire;
            if (enable && state_q == ACTIVE) begin
                v_q <= v_d;
                if (fire && refrac_period != '0) begin
                    state_q <= REFRACTORY;
                    cnt_q   <= refrac_period;
                end
            end else if (enable) begin
                cnt_q <= cnt_q - REFRAC_W'(1);
                if (cnt_q == REFRAC_W'(1)) state_q <= ACTIVE;
            end
        end
    end

    assign output_spike       = spike_q;
    assign membrane_potential = v_q;
    assign refractory         = state_q == REFRACTORY;
endmodule

// File: tb/tb_lif_neuron_mc.sv
// tb_lif_neuron_mc: scoreboard bench for lif_neuron_mc with directed scenarios
// and randomized steps checked against an integer reference model.
module tb_lif_neuron_mc;
    localparam int N = 8, WW = 8, PW = 16, LW = 4, RW = 4;

    logic                 clk = 1'b0, rst = 1'b1, enable = 1'b0, reset_mode = 1'b0;
    logic [N-1:0]         input_spike = '0;
    logic [N*WW-1:0]      weights = '0;
    logic signed [PW-1:0] threshold = '0;
    logic [LW-1:0]        leak_shift = '0;
    logic [RW-1:0]        refrac_period = '0;
    logic                 output_spike, refractory;
    logic signed [PW-1:0] membrane_potential;

    lif_neuron_mc #(.NUM_INPUTS(N), .WEIGHT_W(WW), .POT_W(PW), .LEAK_SHIFT_W(LW), .REFRAC_W(RW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .input_spike(input_spike), .weights(weights),
        .threshold(threshold), .leak_shift(leak_shift), .refrac_period(refrac_period),
        .reset_mode(reset_mode), .output_spike(output_spike),
        .membrane_potential(membrane_potential), .refractory(refractory)
    );

    always #5 clk = ~clk;

    typedef struct {bit spk; int v; bit rf;} exp_t;
    exp_t       q[$];
    int         total = 0, bad = 0;
    int         mv = 0, mcnt = 0;
    logic [7:0] w[N];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int clamp(input int x);
        return x > 32767 ? 32767 : x < -32768 ? -32768 : x;
    endfunction

    // Reference: mcnt counts remaining inert steps; V kept as a plain integer.
    function automatic exp_t model(input logic [N-1:0] sp);
        exp_t e;
        int s, vn;
        e.spk = 1'b0;
        if (mcnt > 0) mcnt--;
        else begin
            s = 0;
            for (int i = 0; i < N; i++) if (sp[i]) s += int'($signed(w[i]));
            vn = clamp((leak_shift != 0 ? mv - (mv >>> leak_shift) : mv) + s);
            if (vn >= int'(threshold)) begin
                e.spk = 1'b1;
                mv    = reset_mode ? clamp(vn - int'(threshold)) : 0;
                mcnt  = int'(refrac_period);
            end else mv = vn;
        end
        e.v  = mv;
        e.rf = mcnt > 0;
        return e;
    endfunction

    task automatic drive(input bit en, input logic [N-1:0] sp);
        @(negedge clk);
        enable      = en;
        input_spike = sp;
        for (int i = 0; i < N; i++) weights[i*WW +: WW] = w[i];
        if (en) q.push_back(model(sp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst         = 1'b1;
            enable      = 1'($urandom);
            input_spike = N'($urandom);
            @(posedge clk);
            #1;
        end
        mv     = 0;
        mcnt   = 0;
        rst    = 1'b0;
        enable = 1'b0;
    endtask

    task automatic set_w(input logic [7:0] v);
        for (int i = 0; i < N; i++) w[i] = v;
    endtask

    initial begin : monitor
        bit   r, e;
        int   sv;
        bit   sr;
        exp_t x;
        forever begin
            @(posedge clk);
            r  = rst;
            e  = enable;
            sv = mv;
            sr = mcnt > 0;
            @(negedge clk);
            if (r) begin
                chk("rst_spike", output_spike, 0);
                chk("rst_v", membrane_potential, 0);
                chk("rst_refr", refractory, 0);
            end else if (e) begin
                if (q.size() == 0) chk("sb_empty", q.size(), 1);
                else begin
                    x = q.pop_front();
                    chk("sb_spike", output_spike, x.spk);
                    chk("sb_v", membrane_potential, x.v);
                    chk("sb_refr", refractory, x.rf);
                end
            end else begin
                chk("idle_spike", output_spike, 0);
                chk("idle_v", membrane_potential, sv);
                chk("idle_refr", refractory, sr);
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) w[i] = 8'($urandom);
        threshold = PW'($urandom);
        do_reset(2);
        chk("reset_v", membrane_potential, 0);
        chk("reset_spike", output_spike, 0);
        chk("reset_refr", refractory, 0);

        leak_shift = 0; threshold = 100; reset_mode = 0; refrac_period = 0; set_w(8'd10);
        drive(1, 8'h0F); chk("int_v1", membrane_potential, 40);
        drive(1, 8'h0F); chk("int_v2", membrane_potential, 80);
        drive(1, 8'h0F); chk("int_fire", output_spike, 1); chk("int_v3", membrane_potential, 0);
        drive(0, 8'h0F); chk("int_pulse_end", output_spike, 0);

        w[0] = 8'd64;
        drive(1, 8'h01); chk("leak_pre", membrane_potential, 64);
        leak_shift = 2;
        drive(1, 8'h00); chk("leak_v1", membrane_potential, 48);
        repeat (3) drive(0, 8'h00);
        chk("leak_hold", membrane_potential, 48);
        drive(1, 8'h00); chk("leak_v2", membrane_potential, 36);
        repeat (3) drive(0, 8'h00);
        drive(1, 8'h00); chk("leak_v3", membrane_potential, 27);

        do_reset(1);
        threshold = 100; reset_mode = 1; refrac_period = 3; leak_shift = 0; set_w(8'd65);
        drive(1, 8'h03);
        chk("sub_fire", output_spike, 1); chk("sub_v", membrane_potential, 30); chk("sub_refr", refractory, 1);
        set_w(8'd50); refrac_period = 7;
        for (int k = 0; k < 3; k++) begin
            drive(1, 8'h01);
            chk("refr_hold_v", membrane_potential, 30);
            chk("refr_flag", refractory, k < 2);
        end
        drive(1, 8'h01); chk("refr_exit_v", membrane_potential, 80); chk("refr_exit_flag", refractory, 0);
        drive(1, 8'h01); chk("refr2_enter", refractory, 1);
        do_reset(1);
        chk("refr_rst_v", membrane_potential, 0); chk("refr_rst_flag", refractory, 0);
        chk("refr_rst_spike", output_spike, 0);

        refrac_period = 0; reset_mode = 0; threshold = 100; set_w(8'h80);
        repeat (32) drive(1, 8'hFF);
        chk("sat_v32", membrane_potential, -32768);
        drive(1, 8'hFF); chk("sat_v33", membrane_potential, -32768);

        do_reset(1);
        threshold = 10; reset_mode = 1; set_w(8'd0); w[0] = 8'd35;
        drive(1, 8'h01); chk("rep_s1", output_spike, 1); chk("rep_v1", membrane_potential, 25);
        drive(1, 8'h00); chk("rep_s2", output_spike, 1); chk("rep_v2", membrane_potential, 15);
        drive(1, 8'h00); chk("rep_s3", output_spike, 1); chk("rep_v3", membrane_potential, 5);
        drive(1, 8'h00); chk("rep_s4", output_spike, 0); chk("rep_v4", membrane_potential, 5);

        repeat (600) begin
            if ($urandom_range(0, 49) == 0) do_reset(int'($urandom_range(1, 2)));
            else begin
                if ($urandom_range(0, 9) == 0) begin
                    threshold     = PW'(int'($urandom_range(0, 600)) - 100);
                    leak_shift    = LW'($urandom);
                    reset_mode    = 1'($urandom);
                    refrac_period = RW'($urandom_range(0, 5));
                end
                for (int i = 0; i < N; i++) w[i] = 8'($urandom);
                drive($urandom_range(0, 3) != 0, N'($urandom));
            end
        end
        drive(0, 8'h00);
        drive(0, 8'h00);
        chk("sb_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
